// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack: load, call, ret, branch and inc
// commands in fixed priority, plus sticky overflow/underflow flags.
module pc_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int STEP  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in,
    input  logic [WIDTH-1:0]         offset,
    input  logic                     load,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     branch,
    input  logic                     inc,
    input  logic                     stall,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     stack_empty,
    output logic                     stack_full,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [SPW-1:0]   DEPTH_SP = SPW'(DEPTH);

    logic [WIDTH-1:0] stack [DEPTH];

    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [SPW-1:0]   sp_reg, sp_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;

    logic             empty, full;
    logic             do_load, do_call, do_ret, do_branch, do_inc;
    logic             push, pop, ovf_set, unf_set;
    logic [WIDTH-1:0] ret_addr;
    logic [WIDTH-1:0] top;
    logic [AW-1:0]    push_idx, top_idx;

    assign empty = (sp_reg == '0);
    assign full  = (sp_reg == DEPTH_SP);

    // Only the highest-priority asserted command is allowed to have any effect.
    assign do_load   = !stall && load;
    assign do_call   = !stall && !load && call;
    assign do_ret    = !stall && !load && !call && ret;
    assign do_branch = !stall && !load && !call && !ret && branch;
    assign do_inc    = !stall && !load && !call && !ret && !branch && inc;

    assign push    = do_call && !full;
    assign ovf_set = do_call && full;
    assign pop     = do_ret && !empty;
    assign unf_set = do_ret && empty;

    assign ret_addr = pc_reg + STEP_W;
    assign push_idx = sp_reg[AW-1:0];
    // When full, the low bits wrap to zero and minus one lands on DEPTH-1.
    assign top_idx  = sp_reg[AW-1:0] - AW'(1);
    assign top      = stack[top_idx];

    always_comb begin
        pc_next = pc_reg;
        sp_next = sp_reg;
        if (do_load) begin
            pc_next = in;
        end else if (push) begin
            pc_next = in;
            sp_next = sp_reg + SPW'(1);
        end else if (pop) begin
            pc_next = top;
            sp_next = sp_reg - SPW'(1);
        end else if (do_branch) begin
            pc_next = pc_reg + offset;
        end else if (do_inc) begin
            pc_next = pc_reg + STEP_W;
        end
    end

    // Clear acts even during stall; a fresh error on the same edge wins.
    always_comb begin
        ovf_next = err_clr ? 1'b0 : ovf_reg;
        unf_next = err_clr ? 1'b0 : unf_reg;
        if (ovf_set) ovf_next = 1'b1;
        if (unf_set) unf_next = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg  <= '0;
            sp_reg  <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            pc_reg  <= pc_next;
            sp_reg  <= sp_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    // Storage is left uncleared by reset; entries above sp are never read.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            stack[push_idx] <= ret_addr;
        end
    end

    assign out           = pc_reg;
    assign sp            = sp_reg;
    assign stack_empty   = empty;
    assign stack_full    = full;
    assign overflow_err  = ovf_reg;
    assign underflow_err = unf_reg;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed scenarios plus randomized commands
// checked against a queue-based reference model.
module tb_pc_stack;

    localparam int W = 16;
    localparam int D = 8;
    localparam int S = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in, offset;
    logic         load, call, ret, branch, inc, stall, err_clr;
    logic [W-1:0] out;
    logic [3:0]   sp;
    logic         stack_empty, stack_full, overflow_err, underflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [W-1:0] m_pc;
    logic [W-1:0] m_q[$];
    logic         m_ovf, m_unf;

    pc_stack #(.WIDTH(W), .DEPTH(D), .STEP(S)) dut (
        .clk(clk), .reset(reset), .in(in), .offset(offset),
        .load(load), .call(call), .ret(ret), .branch(branch), .inc(inc),
        .stall(stall), .err_clr(err_clr), .out(out), .sp(sp),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic clear_cmds();
        load = 0; call = 0; ret = 0; branch = 0; inc = 0; stall = 0; err_clr = 0;
    endtask

    task automatic model_step();
        logic os, us;
        os = 0; us = 0;
        if (!stall) begin
            if (load) m_pc = in;
            else if (call) begin
                if (m_q.size() == D) os = 1;
                else begin m_q.push_back(m_pc + W'(S)); m_pc = in; end
            end else if (ret) begin
                if (m_q.size() == 0) us = 1;
                else m_pc = m_q.pop_back();
            end else if (branch) m_pc = m_pc + offset;
            else if (inc) m_pc = m_pc + W'(S);
        end
        if (err_clr) begin m_ovf = 0; m_unf = 0; end
        if (os) m_ovf = 1;
        if (us) m_unf = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) model_step();
    endtask

    task automatic do_reset();
        clear_cmds();
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        m_pc = 0; m_q.delete(); m_ovf = 0; m_unf = 0;
    endtask

    task automatic test_reset();
        clear_cmds(); in = 16'h0055; offset = 0;
        reset = 1;
        #2;
        n_checks++; if (out !== 16'h0) begin n_fail++; $display("FAIL reset_out got %h want 0000", out); end
        n_checks++; if (sp !== 4'd0) begin n_fail++; $display("FAIL reset_sp got %0d want 0", sp); end
        n_checks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full got %b%b want 10", stack_empty, stack_full); end
        n_checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", overflow_err, underflow_err); end
        call = 1; inc = 1;
        @(posedge clk); #1;
        n_checks++; if (out !== 16'h0 || sp !== 4'd0) begin n_fail++; $display("FAIL reset_hold got out=%h sp=%0d want 0000/0", out, sp); end
        do_reset();
        $display("test_reset done");
    endtask

    task automatic test_inc();
        do_reset();
        inc = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (out !== W'(i) || sp !== 4'd0) begin n_fail++; $display("FAIL inc_%0d got out=%h sp=%0d want %h/0", i, out, sp, W'(i)); end
        end
        inc = 0;
        $display("test_inc done out=%h", out);
    endtask

    task automatic test_call_ret();
        do_reset();
        load = 1; in = 16'h0010; tick(); load = 0;
        call = 1; in = 16'h0200; tick(); call = 0;
        n_checks++; if (out !== 16'h0200 || sp !== 4'd1) begin n_fail++; $display("FAIL call got out=%h sp=%0d want 0200/1", out, sp); end
        inc = 1; tick(); tick(); inc = 0;
        n_checks++; if (out !== 16'h0202) begin n_fail++; $display("FAIL call_inc got %h want 0202", out); end
        ret = 1; tick(); ret = 0;
        n_checks++; if (out !== 16'h0011 || sp !== 4'd0 || stack_empty !== 1'b1) begin n_fail++; $display("FAIL ret got out=%h sp=%0d empty=%b want 0011/0/1", out, sp, stack_empty); end
        $display("test_call_ret done out=%h", out);
    endtask

    task automatic test_wrap();
        do_reset();
        load = 1; in = 16'hFFFF; tick(); load = 0;
        inc = 1; tick(); inc = 0;
        n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap got %h want 0000", out); end
        load = 1; in = 16'h0005; tick(); load = 0;
        branch = 1; offset = 16'hFFFA; tick(); branch = 0;
        n_checks++; if (out !== 16'hFFFF) begin n_fail++; $display("FAIL branch_wrap got %h want FFFF", out); end
        call = 1; in = 16'h0010; tick(); call = 0;
        ret = 1; tick(); ret = 0;
        n_checks++; if (out !== 16'h0000 || overflow_err !== 1'b0) begin n_fail++; $display("FAIL call_ret_wrap got out=%h ovf=%b want 0000/0", out, overflow_err); end
        $display("test_wrap done");
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        call = 1;
        for (int i = 0; i < 9; i++) begin
            in = W'((i + 1) * 16'h0100);
            tick();
            if (i < 8) begin
                n_checks++; if (out !== in || sp !== 4'(i + 1) || stack_full !== (i == 7) || overflow_err !== 1'b0) begin n_fail++; $display("FAIL fill_%0d got out=%h sp=%0d full=%b ovf=%b want %h/%0d/%b/0", i, out, sp, stack_full, overflow_err, in, i + 1, i == 7); end
            end else begin
                n_checks++; if (out !== 16'h0800 || sp !== 4'd8 || overflow_err !== 1'b1) begin n_fail++; $display("FAIL overflow got out=%h sp=%0d ovf=%b want 0800/8/1", out, sp, overflow_err); end
            end
        end
        call = 0; ret = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (out !== W'((7 - i) * 16'h0100 + 1) || sp !== 4'(7 - i)) begin n_fail++; $display("FAIL pop_%0d got out=%h sp=%0d want %h/%0d", i, out, sp, W'((7 - i) * 16'h0100 + 1), 7 - i); end
        end
        tick(); ret = 0;
        n_checks++; if (out !== 16'h0001 || sp !== 4'd0 || underflow_err !== 1'b1 || overflow_err !== 1'b1) begin n_fail++; $display("FAIL underflow got out=%h sp=%0d unf=%b ovf=%b want 0001/0/1/1", out, sp, underflow_err, overflow_err); end
        err_clr = 1; tick(); err_clr = 0;
        n_checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b%b want 00", overflow_err, underflow_err); end
        ret = 1; err_clr = 1; tick(); ret = 0; err_clr = 0;
        n_checks++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL set_wins got %b want 1", underflow_err); end
        $display("test_overflow_underflow done");
    endtask

    task automatic test_priority();
        do_reset();
        load = 1; in = 16'h0050; tick(); load = 0;
        load = 1; call = 1; inc = 1; in = 16'h1234; tick(); clear_cmds();
        n_checks++; if (out !== 16'h1234 || sp !== 4'd0 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL load_call_inc got out=%h sp=%0d flags=%b%b want 1234/0/00", out, sp, overflow_err, underflow_err); end
        call = 1; in = 16'h0300; tick(); call = 0;
        stall = 1; call = 1; in = 16'h0999; tick(); clear_cmds();
        n_checks++; if (out !== 16'h0300 || sp !== 4'd1) begin n_fail++; $display("FAIL stall_call got out=%h sp=%0d want 0300/1", out, sp); end
        ret = 1; branch = 1; offset = 16'h0100; tick(); clear_cmds();
        n_checks++; if (out !== 16'h1235 || sp !== 4'd0) begin n_fail++; $display("FAIL ret_branch got out=%h sp=%0d want 1235/0", out, sp); end
        ret = 1; tick(); ret = 0;
        stall = 1; ret = 1; err_clr = 1; tick(); clear_cmds();
        n_checks++; if (underflow_err !== 1'b0 || out !== 16'h1235) begin n_fail++; $display("FAIL stall_err_clr got unf=%b out=%h want 0/1235", underflow_err, out); end
        $display("test_priority done");
    endtask

    task automatic test_async_reset();
        do_reset();
        ret = 1; tick(); ret = 0;
        call = 1; in = 16'h0400;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (out !== 16'h0400 || sp !== 4'd3 || underflow_err !== 1'b1) begin n_fail++; $display("FAIL pre_async got out=%h sp=%0d unf=%b want 0400/3/1", out, sp, underflow_err); end
        #2 reset = 1;
        #1;
        n_checks++; if (out !== 16'h0 || sp !== 4'd0 || overflow_err !== 1'b0 || underflow_err !== 1'b0 || stack_empty !== 1'b1) begin n_fail++; $display("FAIL async_reset got out=%h sp=%0d flags=%b%b empty=%b want 0000/0/00/1", out, sp, overflow_err, underflow_err, stack_empty); end
        call = 0;
        @(posedge clk); #2;
        reset = 0;
        m_pc = 0; m_q.delete(); m_ovf = 0; m_unf = 0;
        inc = 1; tick(); inc = 0;
        n_checks++; if (out !== 16'h0001) begin n_fail++; $display("FAIL post_reset_inc got %h want 0001", out); end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            load    = ($urandom_range(0, 9) == 0);
            call    = ($urandom_range(0, 3) == 0);
            ret     = ($urandom_range(0, 3) == 0);
            branch  = ($urandom_range(0, 4) == 0);
            inc     = ($urandom_range(0, 2) == 0);
            stall   = ($urandom_range(0, 9) == 0);
            err_clr = ($urandom_range(0, 11) == 0);
            in      = W'($urandom);
            offset  = W'($urandom);
            tick();
            n_checks++;
            if (out !== m_pc || sp !== 4'(m_q.size()) || stack_empty !== (m_q.size() == 0) ||
                stack_full !== (m_q.size() == D) || overflow_err !== m_ovf || underflow_err !== m_unf) begin
                n_fail++;
                $display("FAIL random_%0d got out=%h sp=%0d e/f=%b%b flags=%b%b want %h/%0d/%b%b/%b%b",
                         c, out, sp, stack_empty, stack_full, overflow_err, underflow_err,
                         m_pc, m_q.size(), m_q.size() == 0, m_q.size() == D, m_ovf, m_unf);
            end
        end
        clear_cmds();
        $display("test_random done out=%h sp=%0d", out, sp);
    endtask

    initial begin
        clear_cmds();
        in = 0; offset = 0; reset = 1;
        #3;
        test_reset();
        test_inc();
        test_call_ret();
        test_wrap();
        test_overflow_underflow();
        test_priority();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning address width in bits (legal 4..32).
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning return-stack entries (legal 2..64, power of two).
REQ-003 The module SHALL have parameter STEP, default 1, meaning increment applied by inc and by call return-address computation.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 in  input  WIDTH  absolute target for load and call.
REQ-007 offset  input  WIDTH  two's-complement relative displacement for branch.
REQ-008 load  input  1  absolute jump: out <= in.
REQ-009 call  input  1  push out+STEP, then out <= in.
REQ-010 ret  input  1  pop top of stack into out.
REQ-011 branch  input  1  relative jump: out <= out + offset.
REQ-012 inc  input  1  sequential advance: out <= out + STEP.
REQ-013 stall  input  1  freezes out, stack and pointer for the cycle; command inputs are ignored.
REQ-014 err_clr  input  1  clears sticky error flags.
REQ-015 out  output  WIDTH  registered program counter.
REQ-016 sp  output  clog2(DEPTH)+1  current stack occupancy, 0..DEPTH.
REQ-017 stack_empty  output  1  sp == 0 (combinational from sp).
REQ-018 stack_full  output  1  sp == DEPTH (combinational from sp).
REQ-019 overflow_err  output  1  sticky: call attempted while full.
REQ-020 underflow_err  output  1  sticky: ret attempted while empty.

Function
REQ-021 The block SHALL evaluate one command per non-stalled cycle with fixed priority load > call > ret > branch > inc > hold.
REQ-022 With no command asserted and stall low, out, stack and sp SHALL hold.
REQ-023 All address arithmetic SHALL be modulo 2^WIDTH; out+STEP and out+offset wrap silently with no flag.
REQ-024 call when not full SHALL write (out+STEP) mod 2^WIDTH to stack entry sp, increment sp and load out <= in, all in the same edge.
REQ-025 call when full SHALL leave out, stack and sp unchanged and set overflow_err.
REQ-026 ret when not empty SHALL load out <= entry sp-1 and decrement sp in the same edge; the new out is visible the cycle after the edge.
REQ-027 ret when empty SHALL leave out and sp unchanged and set underflow_err.
REQ-028 A lower-priority command asserted together with a higher one SHALL have no effect, including no flag setting (e.g. load+call: no push, no overflow_err).
REQ-029 Stack contents SHALL be LIFO; entries above sp are don't-care and never observable on out.
REQ-030 stall SHALL take precedence over all commands and over err_clr-independent flag setting; err_clr SHALL still act during stall.
REQ-031 err_clr SHALL clear both sticky flags on the edge; if an error condition occurs on the same edge, the flag SHALL end set (set wins).
REQ-032 Latency from command edge to updated out SHALL be exactly one clock; out SHALL be driven directly from a register.

Reset
REQ-033 While reset is high, out SHALL be 0, sp SHALL be 0, stack_empty 1, stack_full 0, overflow_err 0, underflow_err 0, regardless of clk.
REQ-034 Reset asserted mid-operation (e.g. with call active) SHALL discard the command; stack entry contents need not be cleared.
REQ-035 The first edge after reset deassertion SHALL process commands normally.

Verification
REQ-036 Reset then 3 cycles inc (WIDTH=16, STEP=1) -> out = 0x0001, 0x0002, 0x0003; sp = 0.
REQ-037 out=0x0010, call in=0x0200 -> out=0x0200, sp=1; inc twice then ret -> out=0x0011, sp=0, stack_empty=1.
REQ-038 out=0xFFFF, inc -> out=0x0000; out=0x0005, branch offset=0xFFFA -> out=0xFFFF.
REQ-039 DEPTH=8: nine consecutive calls -> sp=8, stack_full=1 after eighth, ninth leaves out unchanged and sets overflow_err; eight rets return addresses in reverse order; ninth ret sets underflow_err; err_clr clears both.
REQ-040 load+call+inc together with in=0x1234 -> out=0x1234, sp unchanged, no flags; stall with call -> nothing changes.
REQ-041 Assert reset asynchronously between clock edges while sp=3, out=0x0400 -> out=0 and sp=0 before next edge; flags 0.
